// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared state encoding, SPI constants and width helper for the flash cache controller
package spi_flash_pkg;
  typedef enum logic [2:0] {IDLE, CS_ON, SHIFT_OUT, SHIFT_IN, CS_OFF, RESPOND, HOLDOFF} state_t;
  localparam logic [7:0] DEF_READ_CMD = 8'h03;
  localparam int CMD_BITS = 32;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_flash_cache_controller_spi_shift_engine.sv
// spi_shift_engine: mode-0 SPI bit engine with clock divider, 32-bit transmit and byte-wide receive shifters
module spi_shift_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CMD_BITS-1:0] tx_data,
  input  logic [CNT_W-1:0]    nbits,
  input  logic                miso,
  output logic                sck,
  output logic                mosi,
  output logic [7:0]          rx_byte,
  output logic                byte_done,
  output logic                done
);
  localparam int DW = clog2(CLK_DIV) > 0 ? clog2(CLK_DIV) : 1;
  logic act_q, act_d, sck_q, sck_d, byte_done_q, byte_done_d, tick, rise, fall;
  logic [DW-1:0] div_q, div_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CMD_BITS-1:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] rxc_q, rxc_d;
  always_comb begin
    tick = act_q && div_q == DW'(CLK_DIV - 1);
    rise = tick && !sck_q;
    fall = tick && sck_q;
    done = fall && bits_q == CNT_W'(1);
    act_d = start || (act_q && !done);
    div_d = (start || tick) ? '0 : act_q ? div_q + DW'(1) : div_q;
    sck_d = start ? 1'b0 : tick ? !sck_q : sck_q;
    tx_d = start ? tx_data : fall ? tx_q << 1 : tx_q;
    bits_d = start ? nbits : fall ? bits_q - CNT_W'(1) : bits_q;
    rx_d = rise ? {rx_q[6:0], miso} : rx_q;
    rxc_d = start ? 3'd0 : rise ? rxc_q + 3'd1 : rxc_q;
    byte_done_d = rise && rxc_q == 3'd7;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      sck_q <= 1'b0;
      byte_done_q <= 1'b0;
      div_q <= '0;
      bits_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rxc_q <= '0;
    end else begin
      act_q <= act_d;
      sck_q <= sck_d;
      byte_done_q <= byte_done_d;
      div_q <= div_d;
      bits_q <= bits_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rxc_q <= rxc_d;
    end
  end
  assign sck = sck_q;
  assign mosi = tx_q[CMD_BITS-1];
  assign rx_byte = rx_q;
  assign byte_done = byte_done_q;
endmodule

// File: rtl/spi_flash_cache_controller.sv
// spi_flash_cache_controller: direct-mapped line buffer in front of an SPI flash serving core byte fetches
module spi_flash_cache_controller
  import spi_flash_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int LINE_BYTES = 8,
  parameter int NUM_LINES = 4,
  parameter int CLK_DIV = 2,
  parameter logic [7:0] READ_CMD = DEF_READ_CMD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipSel,
  input  logic                  readMem,
  input  logic [ADDR_WIDTH-1:0] addressBus,
  input  logic                  flush,
  output logic [7:0]            dataOut,
  output logic                  ready,
  output logic                  SCK,
  output logic                  CSbar,
  output logic                  DI,
  input  logic                  DO
);
  localparam int OW = clog2(LINE_BYTES);
  localparam int IW0 = clog2(NUM_LINES);
  localparam int IW = IW0 > 0 ? IW0 : 1;
  localparam int TW = ADDR_WIDTH - OW - IW0;
  localparam int BW = OW > 2 ? OW : 2;
  localparam int CW = 16;
  state_t state_q, state_d;
  logic ready_q, ready_d, req, hit, start, tag_we, line_we, mosi, sck, byte_done, done;
  logic [7:0] dout_q, dout_d, rx_byte;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [OW-1:0] off;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] tag, ftag;
  logic [TW-1:0] tag_q [NUM_LINES];
  logic [7:0] line_q [NUM_LINES][LINE_BYTES];
  assign off = addressBus[OW-1:0];
  assign idx = IW'((addressBus >> OW) & ADDR_WIDTH'(NUM_LINES - 1));
  assign tag = TW'(addressBus >> (OW + IW0));
  assign fidx = IW'((faddr_q >> OW) & ADDR_WIDTH'(NUM_LINES - 1));
  assign ftag = TW'(faddr_q >> (OW + IW0));
  always_comb begin
    req = chipSel && readMem;
    hit = valid_q[idx] && tag_q[idx] == tag && !flush;
    state_d = state_q;
    ready_d = 1'b0;
    dout_d = dout_q;
    valid_d = flush ? '0 : valid_q;
    faddr_d = faddr_q;
    bc_d = bc_q;
    start = 1'b0;
    tag_we = 1'b0;
    line_we = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = req && hit;
        dout_d = req && hit ? line_q[idx][off] : dout_q;
        faddr_d = req && !hit ? addressBus : faddr_q;
        state_d = !req ? IDLE : hit ? HOLDOFF : CS_ON;
      end
      CS_ON: begin
        start = 1'b1;
        bc_d = '0;
        state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        bc_d = byte_done ? (bc_q == BW'(3) ? '0 : bc_q + BW'(1)) : bc_q;
        state_d = byte_done && bc_q == BW'(3) ? SHIFT_IN : SHIFT_OUT;
      end
      SHIFT_IN: begin
        line_we = byte_done;
        bc_d = byte_done ? bc_q + BW'(1) : bc_q;
        state_d = done ? CS_OFF : SHIFT_IN;
      end
      CS_OFF: begin
        tag_we = 1'b1;
        valid_d[fidx] = 1'b1;
        ready_d = req && idx == fidx && tag == ftag;
        dout_d = ready_d ? line_q[fidx][off] : dout_q;
        state_d = RESPOND;
      end
      RESPOND: state_d = HOLDOFF;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      dout_q <= '0;
      valid_q <= '0;
      faddr_q <= '0;
      bc_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      faddr_q <= faddr_d;
      bc_q <= bc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (line_we) line_q[fidx][OW'(bc_q)] <= rx_byte;
    if (tag_we) tag_q[fidx] <= ftag;
  end
  spi_shift_engine #(.CLK_DIV(CLK_DIV), .CNT_W(CW)) u_eng (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_data({READ_CMD, 24'((faddr_q >> OW) << OW)}),
    .nbits(CW'(CMD_BITS + 8 * LINE_BYTES)),
    .miso(DO),
    .sck(sck),
    .mosi(mosi),
    .rx_byte(rx_byte),
    .byte_done(byte_done),
    .done(done)
  );
  assign dataOut = dout_q;
  assign ready = ready_q;
  assign SCK = sck;
  assign CSbar = !(state_q == CS_ON || state_q == SHIFT_OUT || state_q == SHIFT_IN);
  assign DI = state_q == CS_ON ? READ_CMD[7] : (state_q == SHIFT_OUT || state_q == SHIFT_IN) && mosi;
endmodule

// File: tb/tb_spi_flash_cache_controller.sv
// tb_spi_flash_cache_controller: vector table, directed corner sequences and randomized reads against a line-level cache model
module tb_spi_flash_cache_controller;
  typedef struct {
    logic [23:0] a;
    logic        f;
    int          lat;
    logic [7:0]  d;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cs = '0, rd = '0, fls = '0;
  logic [1:0] rdy, sck, csb, di, dsig;
  logic [23:0] addr [2];
  logic [7:0] dout [2];
  int total = 0;
  int bad = 0;
  int cached [2][4];
  vec_t tv [8];
  always #5 clk = ~clk;
  spi_flash_cache_controller u0 (
    .clk(clk), .rst(rst), .chipSel(cs[0]), .readMem(rd[0]), .addressBus(addr[0]), .flush(fls[0]),
    .dataOut(dout[0]), .ready(rdy[0]), .SCK(sck[0]), .CSbar(csb[0]), .DI(di[0]), .DO(dsig[0])
  );
  spi_flash_cache_controller #(.CLK_DIV(1), .LINE_BYTES(4)) u1 (
    .clk(clk), .rst(rst), .chipSel(cs[1]), .readMem(rd[1]), .addressBus(addr[1]), .flush(fls[1]),
    .dataOut(dout[1]), .ready(rdy[1]), .SCK(sck[1]), .CSbar(csb[1]), .DI(di[1]), .DO(dsig[1])
  );
  function automatic logic [7:0] fdat(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction
  for (genvar g = 0; g < 2; g++) begin : flash
    int cnt = 0;
    logic [31:0] cmd = '0;
    logic d = 1'b0;
    logic [7:0] b;
    always @(posedge sck[g] or posedge csb[g]) begin
      if (csb[g]) cnt = 0;
      else begin
        if (cnt < 32) cmd = {cmd[30:0], di[g]};
        cnt++;
      end
    end
    always @(negedge sck[g]) begin
      if (!csb[g] && cnt >= 32) begin
        b = fdat(cmd[23:0] + 24'((cnt - 32) / 8));
        d = b[7 - ((cnt - 32) % 8)];
      end
    end
    assign dsig[g] = d;
  end
  function automatic int lbytes(input int g);
    return g != 0 ? 4 : 8;
  endfunction
  function automatic int miss_lat(input int g);
    return g != 0 ? 3 + (32 + 8 * 4) * 2 * 1 : 3 + (32 + 8 * 8) * 2 * 2;
  endfunction
  function automatic void mdl_clear(input int g);
    for (int i = 0; i < 4; i++) cached[g][i] = -1;
  endfunction
  function automatic int mdl_lat(input int g, input logic [23:0] a, input logic f);
    int ln = int'(a) / lbytes(g);
    return (!f && cached[g][ln % 4] == ln) ? 1 : miss_lat(g);
  endfunction
  function automatic void mdl_fill(input int g, input logic [23:0] a, input logic f);
    int ln = int'(a) / lbytes(g);
    if (f) mdl_clear(g);
    cached[g][ln % 4] = ln;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_read(input int g, input logic [23:0] a, input logic f, input int fat,
                         input int lat_exp, input logic [7:0] d_exp, input string nm);
    int lat = 0;
    logic lowcs = 1'b0;
    addr[g] = a;
    cs[g] = 1'b1;
    rd[g] = 1'b1;
    fls[g] = f;
    do begin
      @(posedge clk);
      #1;
      lat++;
      fls[g] = lat == fat;
      lowcs |= !csb[g];
    end while (!rdy[g] && lat < 1000);
    chk({nm, " latency"}, lat, lat_exp);
    chk({nm, " data"}, dout[g], d_exp);
    chk({nm, " cs activity"}, lowcs, lat_exp > 1);
    @(posedge clk);
    #1;
    fls[g] = 1'b0;
    chk({nm, " holdoff"}, rdy[g], 0);
    cs[g] = 1'b0;
    rd[g] = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " quiet"}, rdy[g], 0);
  endtask
  task automatic step(input int g, input logic [23:0] a, input logic f, input int fat,
                      input int lat_exp, input logic [7:0] d_exp, input string nm);
    do_read(g, a, f, fat, lat_exp, d_exp, nm);
    mdl_fill(g, a, f || fat > 0);
  endtask
  task automatic pulse_flush(input int g);
    fls[g] = 1'b1;
    @(posedge clk);
    #1;
    fls[g] = 1'b0;
    chk("flush no ready", rdy[g], 0);
    mdl_clear(g);
  endtask
  task automatic rnd_read(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] a;
      logic f;
      if ($urandom_range(0, 9) == 0) pulse_flush(g);
      a = 24'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) a[23:16] = 8'($urandom);
      f = $urandom_range(0, 7) == 0;
      step(g, a, f, 0, mdl_lat(g, a, f), fdat(a), $sformatf("rnd%0d.%0d", g, i));
    end
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic saw;
    addr[0] = '0;
    addr[1] = '0;
    tv[0] = '{24'h000013, 1'b0, 1, 8'h13};
    tv[1] = '{24'h000030, 1'b0, 387, 8'h30};
    tv[2] = '{24'h000010, 1'b0, 387, 8'h10};
    tv[3] = '{24'h000017, 1'b0, 1, 8'h17};
    tv[4] = '{24'h000018, 1'b0, 387, 8'h18};
    tv[5] = '{24'h00001f, 1'b0, 1, 8'h1f};
    tv[6] = '{24'h000010, 1'b1, 387, 8'h10};
    tv[7] = '{24'h000012, 1'b0, 1, 8'h12};
    mdl_clear(0);
    mdl_clear(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset ready%0d", g), rdy[g], 0);
      chk($sformatf("reset dataOut%0d", g), dout[g], 0);
      chk($sformatf("reset SCK%0d", g), sck[g], 0);
      chk($sformatf("reset CSbar%0d", g), csb[g], 1);
      chk($sformatf("reset DI%0d", g), di[g], 0);
    end
    saw = 1'b0;
    cs[0] = 1'b1;
    addr[0] = 24'h000010;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw |= rdy[0] || !csb[0];
    end
    cs[0] = 1'b0;
    chk("chipSel only", saw, 0);
    step(0, 24'h000010, 1'b0, 0, 387, 8'h10, "cold");
    chk("cold command", flash[0].cmd, 32'h03000010);
    for (int i = 0; i < 8; i++) begin
      step(0, tv[i].a, tv[i].f, 0, tv[i].lat, tv[i].d, $sformatf("vec%0d", i));
    end
    pulse_flush(0);
    step(0, 24'h000010, 1'b0, 0, 387, 8'h10, "after flush");
    addr[0] = 24'h000040;
    cs[0] = 1'b1;
    rd[0] = 1'b1;
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midburst reset CSbar", csb[0], 1);
    chk("midburst reset SCK", sck[0], 0);
    cs[0] = 1'b0;
    rd[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_clear(0);
    mdl_clear(1);
    step(0, 24'h000040, 1'b0, 0, 387, 8'h40, "reread after reset");
    rnd_read(0, 25);
    step(1, 24'h000010, 1'b0, 0, 131, 8'h10, "p cold");
    chk("p cold command", flash[1].cmd, 32'h03000010);
    step(1, 24'h000013, 1'b0, 0, 1, 8'h13, "p hit");
    step(1, 24'h000014, 1'b0, 0, 131, 8'h14, "p next line");
    chk("p next command", flash[1].cmd, 32'h03000014);
    step(1, 24'h000028, 1'b0, 50, 131, 8'h28, "p midflush");
    step(1, 24'h00002b, 1'b0, 0, 1, 8'h2b, "p kept line");
    step(1, 24'h000010, 1'b0, 0, 131, 8'h10, "p flushed line");
    rnd_read(1, 25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_cache_controller.md
Name: spi_flash_cache_controller

Overview:
- Parametrised successor to the byte-wide SPI flash instruction-memory controller. Sits between the AFTAB core bus (chipSel/readMem/addressBus/dataOut/ready) and the SPI flash pins.
- Adds a direct-mapped line buffer: a miss fetches a whole line in one SPI READ burst, and subsequent fetches that hit the buffer complete in one cycle.
- Adds a configurable SPI clock divider and a flush input.

Parameters:
ADDR_WIDTH, 24, core byte-address width; also the SPI address length (24 bits only).
LINE_BYTES, 8, bytes per line; power of two, at least 2.
NUM_LINES, 4, direct-mapped lines; power of two, at least 1.
CLK_DIV, 2, clk cycles per SCK half-period; at least 1.
READ_CMD, 8'h03, SPI read opcode.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
chipSel  input  1  address decoder select for instruction memory
readMem  input  1  core read strobe
addressBus  input  ADDR_WIDTH  byte address
flush  input  1  invalidate all lines
dataOut  output  8  read byte, valid while ready=1
ready  output  1  one-cycle completion pulse
SCK  output  1  SPI clock, mode 0, idles low
CSbar  output  1  flash chip select, active-low
DI  output  1  serial data to flash, MSB first
DO  input  1  serial data from flash

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: ready=0, dataOut=0, SCK=0, CSbar=1, DI=0.
  - All valid bits cleared; FSM goes to IDLE.
  - Reset mid-burst aborts immediately and releases CSbar.
- Address split: offset = addr[log2(LINE_BYTES)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- A request is chipSel & readMem. chipSel without readMem is ignored and produces no ready.
- States: IDLE, CS_ON, SHIFT_OUT, SHIFT_IN, CS_OFF, RESPOND, HOLDOFF.
- IDLE, request at cycle t, hit (valid[index] and tag match, no flush):
  - ready=1 and dataOut=line[index][offset] at t+1 (registered).
  - Next state is HOLDOFF.
- IDLE, request at cycle t, miss: go to CS_ON.
  - t+1: CSbar=0, DI=MSB of command.
  - SHIFT_OUT: 32 bits sent = READ_CMD followed by the line-aligned address (offset bits zero).
  - SHIFT_IN: 8*LINE_BYTES bits received.
  - Bytes are stored in ascending address order, MSB first within each byte.
- SPI timing:
  - Each bit is 2*CLK_DIV cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DI changes only while SCK is low; DO is sampled on the SCK rising edge.
  - Shifting spans N = (32+8*LINE_BYTES)*2*CLK_DIV cycles, from t+2 to t+1+N.
- CS_OFF at t+2+N: CSbar=1, SCK=0, tag written, valid set.
- RESPOND at t+3+N:
  - If the request is still present and its index/tag still match the filled line, ready=1 with the byte; otherwise no ready.
  - Next state is HOLDOFF.
- Defaults: miss latency = 387 cycles; hit latency = 1 cycle.
- HOLDOFF: one cycle in which requests are ignored, so a core still holding readMem is not served twice. Then IDLE.
- Flush:
  - In IDLE, clears all valid bits in that cycle; flush together with a request is treated as a miss.
  - During a burst, the burst completes and the fetched line is marked valid, but all other lines are cleared.
- Address changes during a burst are ignored until RESPOND.
- Offset wrap: the line always starts at the aligned address, so offset LINE_BYTES-1 is served from the same line.
- Consecutive lines have independent tags and no prefetch.
- ready is never high for two consecutive cycles.
- CSbar is never low outside CS_ON..SHIFT_IN.

Decomposition:
- Package spi_flash_pkg holds:
  - state encoding localparams;
  - the default READ_CMD;
  - a clog2 function for the offset/index widths;
  - the SPI bit-count constant 32.
- One sub-module, spi_shift_engine, contains:
  - the CLK_DIV counter, SCK generation and bit counter;
  - a 32-bit transmit shift register and an 8-bit receive shift register with a byte_done strobe.
  - It is started by the top FSM with a bit count and reports done.
- The top module holds the tag/valid arrays, the line storage, and the FSM.

Test Plan:
- Cold miss: reset, then read 0x000010 (flash[0x10..0x17] = 0x10..0x17). Required:
  - CSbar low for the burst; DI carries 0x03,0x00,0x00,0x10;
  - ready at t+387 with dataOut=0x10.
- Hit: read 0x000013 after the cold miss -> ready at t+1 with 0x13; CSbar stays high.
- Conflict miss, NUM_LINES=4 and LINE_BYTES=8: read 0x000030 (same index 2, new tag) -> new burst; then 0x000010 misses again.
- Flush: hit on 0x000010, pulse flush, read 0x000010 again -> full burst, ready after 387 cycles.
- Reset mid-burst: assert rst 100 cycles into a miss -> CSbar=1 and SCK=0 immediately; re-reading the same address performs a full burst.
- Parametric: CLK_DIV=1, LINE_BYTES=4 -> SCK period 2 cycles; miss latency 3+64*2=131 cycles. Request held after ready -> no second ready during HOLDOFF.
